int_tx_frame: RTL and testbench
===============================

Name:
int_tx_frame

Overview:
- Parametrised successor to the ALU-result-to-UART-TX interface.
- Latches a DATA_W-bit result when `enviar` is pulsed.
- Serialises the result into bytes, with an optional header byte and an optional XOR checksum byte, and pushes them into the UART TX FIFO.
- Obeys `fifo_full` backpressure. Sits between the ALU/result register and the TX FIFO write port.

Parameters:
- DATA_W, 32: width of RESULTADO. Range 8..64.
- NBYTES, (DATA_W+7)/8: derived number of data bytes. Not overridable.
- HEADER_EN, 1: 1 means a header byte is sent before the data.
- HEADER_BYTE, 8'hA5: value of the header byte.
- CSUM_EN, 1: 1 means an XOR-of-data-bytes checksum byte is sent after the data.
- LSB_FIRST, 1: 1 sends byte 0 (bits 7:0) first; 0 sends the most significant byte first.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- enviar  in  1  start request. Sampled only in IDLE.
- fifo_full  in  1  TX FIFO full. No write may occur while it is high.
- RESULTADO  in  DATA_W  value to transmit. Sampled in the cycle `enviar` is accepted.
- WR_FIFO  out  1  FIFO write strike. A byte is written on each rising CLK edge where WR_FIFO=1.
- data_fifo  out  8  byte presented to the FIFO.
- busy  out  1  high from the cycle after acceptance until the frame completes.
- done  out  1  one-cycle pulse after the last byte has been written.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, shift register=0, checksum=0, byte counter=0, data_fifo=0, busy=0, done=0. WR_FIFO=0 while reset is asserted.
- States: IDLE, HDR, DATA, CSUM, FIN.
- Frame length: FLEN = HEADER_EN + NBYTES + CSUM_EN.
- Bytes are presented from registers. WR_FIFO = (state in HDR/DATA/CSUM) && !fifo_full, a combinational Mealy output. A byte is consumed only on an edge where WR_FIFO=1.
- IDLE:
  - enviar=1 loads RESULTADO, zero-extended to NBYTES*8, into the shift register. Clears the checksum and sets byte counter=0.
  - Next state is HDR if HEADER_EN, else DATA.
  - data_fifo is loaded with the first byte to send (header or first data byte).
- HDR:
  - On a write, load data_fifo with the first data byte and go to DATA.
  - If fifo_full=1, hold state and data_fifo.
- DATA:
  - On a write, checksum ^= data_fifo and byte counter++.
  - If the counter reaches NBYTES: go to CSUM, with data_fifo = checksum ^ current byte, if CSUM_EN. Otherwise go to FIN.
  - Otherwise load the next byte: shift right by 8 if LSB_FIRST, left by 8 otherwise.
- CSUM: on a write, go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in HDR, DATA, CSUM and FIN.
- Latency with the FIFO never full:
  - enviar accepted at edge 0.
  - Writes occur at edges 1..FLEN.
  - done is high in the cycle after edge FLEN.
  - A new enviar is accepted no earlier than the edge after done. Minimum 2 idle edges between frames.
- enviar while busy: ignored, no queuing. RESULTADO changes while busy: no effect.
- fifo_full may toggle on any cycle. The stall is indefinite, with no timeout. Bytes are never dropped or duplicated.
- Reset asserted mid-frame: the frame is abandoned immediately. No further WR_FIFO. After release the block is in IDLE.
- Padding: when DATA_W is not a multiple of 8, the top byte is zero-padded. The padding participates in the checksum.

Decomposition:
- Package int_tx_pkg holds:
  - state enum {IDLE, HDR, DATA, CSUM, FIN};
  - the default HEADER_BYTE constant;
  - the function nbytes(DATA_W).
- One natural sub-module: tx_byte_serializer, which contains the load/shift register, byte counter, LSB/MSB select and last-byte flag. The FSM and checksum stay in the top level.

Test Plan:
- Defaults, RESULTADO=32'h12345678, enviar pulse, fifo_full=0 -> six consecutive WR_FIFO cycles with data_fifo A5,78,56,34,12,08. done pulses one cycle later. busy spans exactly those 7 cycles.
- Same frame, fifo_full=1 for 3 cycles right after the header is written -> WR_FIFO=0 and data_fifo=78 held for 3 cycles, then 78,56,34,12,08 are written. Total 6 writes, no duplicates.
- LSB_FIRST=0, HEADER_EN=0, CSUM_EN=0, RESULTADO=32'hDEADBEEF -> writes DE,AD,BE,EF, then the done pulse.
- DATA_W=12, RESULTADO=12'hABC -> writes A5,BC,0A,B6 (the padded top byte is 0A).
- enviar pulsed again during the third byte with RESULTADO=32'hFFFFFFFF -> ignored. The frame content is unchanged at A5,78,56,34,12,08.
- RESET=0 asserted during the DATA state -> WR_FIFO drops in the same cycle and busy=0. After release, a new frame with RESULTADO=32'h00000001 sends A5,01,00,00,00,01 exactly.

Source files
------------

// File: rtl/int_tx_frame_pkg.sv
// Shared definitions for the result-to-UART-TX framer.
//   state_t         : frame FSM states
//   HEADER_BYTE_DEF : default header byte value
//   nbytes()        : number of bytes needed to carry a DATA_W-bit value
package int_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/int_tx_frame_if.sv
// Request/FIFO-side bundle of the framer.
//   master : framer side (takes enviar/RESULTADO/fifo_full, drives the FIFO write and status)
//   slave  : producer/FIFO side
interface int_tx_frame_if #(
  parameter int DATA_W = 32
) ();
  logic              enviar;
  logic              fifo_full;
  logic [DATA_W-1:0] RESULTADO;
  logic              WR_FIFO;
  logic [7:0]        data_fifo;
  logic              busy;
  logic              done;

  modport master (
    input  enviar, fifo_full, RESULTADO,
    output WR_FIFO, data_fifo, busy, done
  );

  modport slave (
    output enviar, fifo_full, RESULTADO,
    input  WR_FIFO, data_fifo, busy, done
  );
endinterface

// File: rtl/int_tx_frame_serializer.sv
// Byte serializer: holds the zero-extended result, walks it one byte per
// shift in LSB-first or MSB-first order, and flags the last data byte.
//   load/din  : capture a new value, counter cleared
//   shift     : advance to the next byte (one data byte consumed)
//   load_byte : first byte of din (used when no header precedes the data)
//   cur_byte  : first byte of the held value
//   nxt_byte  : byte that follows the one currently being sent
//   last      : the byte being sent now is the final data byte
module tx_byte_serializer
  import int_tx_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        load_byte,
  output logic [7:0]        cur_byte,
  output logic [7:0]        nxt_byte,
  output logic              last
);
  localparam int NB = nbytes(DATA_W);
  localparam int W  = NB * 8;
  localparam int CW = $clog2(NB + 1);

  logic [W-1:0]  sreg, ld_val, shifted;
  logic [CW-1:0] cnt;

  // Padding bits above DATA_W are zero and still travel as data.
  assign ld_val  = W'(din);
  assign shifted = LSB_FIRST ? (sreg >> 8) : (sreg << 8);

  function automatic logic [7:0] pick(input logic [W-1:0] v);
    return LSB_FIRST ? v[7:0] : v[W-1 -: 8];
  endfunction

  assign load_byte = pick(ld_val);
  assign cur_byte  = pick(sreg);
  assign nxt_byte  = pick(shifted);
  assign last      = (cnt == CW'(NB - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= ld_val;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= shifted;
      cnt  <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/int_tx_frame.sv
// Frames a DATA_W-bit result as [header] data bytes [xor checksum] and
// writes it into the UART TX FIFO, stalling on fifo_full.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-low
//   bus   : enviar/RESULTADO/fifo_full in; WR_FIFO/data_fifo/busy/done out
module int_tx_frame
  import int_tx_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
  parameter bit         CSUM_EN     = 1'b1,
  parameter bit         LSB_FIRST   = 1'b1
) (
  input  logic           CLK,
  input  logic           RESET,
  int_tx_frame_if.master bus
);
  state_t     state;
  logic [7:0] data_q, csum;
  logic       busy_q, done_q;
  logic       wr, load, shift, last;
  logic [7:0] load_byte, cur_byte, nxt_byte;

  // Mealy write strobe: a byte leaves only on an edge where this is high.
  assign wr    = ((state == HDR) || (state == DATA) || (state == CSUM)) && !bus.fifo_full;
  assign load  = (state == IDLE) && bus.enviar;
  assign shift = (state == DATA) && wr;

  tx_byte_serializer #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_ser (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (load),
    .shift    (shift),
    .din      (bus.RESULTADO),
    .load_byte(load_byte),
    .cur_byte (cur_byte),
    .nxt_byte (nxt_byte),
    .last     (last)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      data_q <= '0;
      csum   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.enviar) begin
            csum   <= '0;
            busy_q <= 1'b1;
            if (HEADER_EN) begin
              data_q <= HEADER_BYTE;
              state  <= HDR;
            end else begin
              data_q <= load_byte;
              state  <= DATA;
            end
          end
        end
        HDR: if (wr) begin
          data_q <= cur_byte;
          state  <= DATA;
        end
        DATA: if (wr) begin
          csum <= csum ^ data_q;
          if (last) begin
            if (CSUM_EN) begin
              // Checksum byte must include the byte leaving on this edge.
              data_q <= csum ^ data_q;
              state  <= CSUM;
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
            end
          end else begin
            data_q <= nxt_byte;
          end
        end
        CSUM: if (wr) begin
          state  <= FIN;
          done_q <= 1'b1;
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.WR_FIFO   = wr;
  assign bus.data_fifo = data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_int_tx_frame.sv
module tb_int_tx_frame;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // 0: defaults; 1: MSB-first, no header, no checksum; 2: DATA_W=12
  int_tx_frame_if #(.DATA_W(32)) b0 ();
  int_tx_frame_if #(.DATA_W(32)) b1 ();
  int_tx_frame_if #(.DATA_W(12)) b2 ();

  int_tx_frame u0 (.CLK(CLK), .RESET(RESET), .bus(b0));
  int_tx_frame #(.DATA_W(32), .HEADER_EN(1'b0), .CSUM_EN(1'b0), .LSB_FIRST(1'b0))
    u1 (.CLK(CLK), .RESET(RESET), .bus(b1));
  int_tx_frame #(.DATA_W(12)) u2 (.CLK(CLK), .RESET(RESET), .bus(b2));

  logic [7:0] q0[$], q1[$], q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every FIFO write pops the next expected byte.
  task automatic mon_pop(input int sel, input logic [7:0] d);
    logic [7:0] e;
    int n;
    case (sel)
      0: n = q0.size();
      1: n = q1.size();
      default: n = q2.size();
    endcase
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL wr%0d_unexpected: got %0h expected no write", sel, d);
    end else begin
      case (sel)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("wr%0d_byte", sel), 64'(d), 64'(e));
    end
  endtask

  always @(negedge CLK) if (RESET && b0.WR_FIFO) mon_pop(0, b0.data_fifo);
  always @(negedge CLK) if (RESET && b1.WR_FIFO) mon_pop(1, b1.data_fifo);
  always @(negedge CLK) if (RESET && b2.WR_FIFO) mon_pop(2, b2.data_fifo);

  task automatic drive(input int sel, input logic env, input logic [63:0] res, input logic full);
    case (sel)
      0: begin b0.enviar = env; b0.RESULTADO = res[31:0]; b0.fifo_full = full; end
      1: begin b1.enviar = env; b1.RESULTADO = res[31:0]; b1.fifo_full = full; end
      default: begin b2.enviar = env; b2.RESULTADO = res[11:0]; b2.fifo_full = full; end
    endcase
  endtask

  task automatic sample(input int sel, output logic wr, output logic bz, output logic dn,
                        output logic [7:0] d);
    case (sel)
      0: begin wr = b0.WR_FIFO; bz = b0.busy; dn = b0.done; d = b0.data_fifo; end
      1: begin wr = b1.WR_FIFO; bz = b1.busy; dn = b1.done; d = b1.data_fifo; end
      default: begin wr = b2.WR_FIFO; bz = b2.busy; dn = b2.done; d = b2.data_fifo; end
    endcase
  endtask

  // Cycle i is the period after accept edge i-1; writes land at edges 1..flen
  // when never stalled, done shows in cycle flen+1.
  task automatic run_frame(input int sel, input logic [63:0] res, input int flen,
                           input int st_from, input int st_len, input logic [7:0] hold,
                           input int reenv_at);
    int wrc = 0, bc = 0, di = -1;
    logic wr, bz, dn, full;
    logic [7:0] d;
    @(posedge CLK); #1 drive(sel, 1'b1, res, 1'b0);
    @(posedge CLK); #1;
    for (int i = 1; i <= 60 && di < 0; i++) begin
      full = (i >= st_from) && (i < st_from + st_len);
      drive(sel, i == reenv_at, (i == reenv_at) ? 64'hFFFF_FFFF_FFFF_FFFF : res, full);
      @(negedge CLK);
      sample(sel, wr, bz, dn, d);
      if (wr) wrc++;
      if (bz) bc++;
      if (dn) di = i;
      if (full) begin
        chk("stall_no_write", 64'(wr), 64'd0);
        chk("stall_hold_byte", 64'(d), 64'(hold));
      end
      @(posedge CLK); #1;
    end
    chk($sformatf("frame%0d_writes", sel), 64'(wrc), 64'(flen));
    chk($sformatf("frame%0d_done_cycle", sel), 64'(di), 64'(flen + 1 + st_len));
    chk($sformatf("frame%0d_busy_cycles", sel), 64'(bc), 64'(flen + 1 + st_len));
    drive(sel, 1'b0, res, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0;
    drive(0, 1'b0, 64'd0, 1'b0);
    drive(1, 1'b0, 64'd0, 1'b0);
    drive(2, 1'b0, 64'd0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wr", 64'(b0.WR_FIFO), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);
    chk("rst_data", 64'(b0.data_fifo), 64'd0);
    chk("rst_busy1", 64'(b1.busy), 64'd0);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Basic frame
    q0 = {8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame(0, 64'h12345678, 6, 0, 0, 8'h00, 0);

    // Stall for 3 cycles right after the header is written
    q0 = {8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame(0, 64'h12345678, 6, 2, 3, 8'h78, 0);

    // Second enviar during the third byte is ignored
    q0 = {8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run_frame(0, 64'h12345678, 6, 0, 0, 8'h00, 3);

    // MSB first, no header, no checksum
    q1 = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(1, 64'hDEADBEEF, 4, 0, 0, 8'h00, 0);

    // 12-bit result, padded top byte
    q2 = {8'hA5, 8'hBC, 8'h0A, 8'hB6};
    run_frame(2, 64'hABC, 4, 0, 0, 8'h00, 0);

    // Reset during DATA: A5,78,56 go out at edges 1..3, reset lands in cycle 4
    q0 = {8'hA5, 8'h78, 8'h56};
    @(posedge CLK); #1 drive(0, 1'b1, 64'h12345678, 1'b0);
    @(posedge CLK); #1 drive(0, 1'b0, 64'h12345678, 1'b0);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;
    chk("midrst_wr", 64'(b0.WR_FIFO), 64'd0);
    chk("midrst_busy", 64'(b0.busy), 64'd0);
    chk("midrst_q_drained", 64'(q0.size()), 64'd0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    q0 = {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    run_frame(0, 64'h00000001, 6, 0, 0, 8'h00, 0);

    // Idle tail: nothing queued or duplicated must appear
    repeat (10) @(posedge CLK);
    #1;
    chk("end_q0_empty", 64'(q0.size()), 64'd0);
    chk("end_q1_empty", 64'(q1.size()), 64'd0);
    chk("end_q2_empty", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
